// File: rtl/i2c_arb_pkg.sv
// Shared types and default sizing for the I2C access arbiter.
// The command struct is sized by the package widths, so override these together with the top parameters.
package i2c_arb_pkg;

    localparam int ARB_NREQ       = 4;
    localparam int ARB_DATAWIDTH  = 8;
    localparam int ARB_ADDRWIDTH  = 6;
    localparam int ARB_WR_HOLD    = 4;
    localparam int ARB_RD_TIMEOUT = 63;
    localparam int ARB_LOAD_SEL   = 3;
    localparam int ARB_IDXW       = $clog2(ARB_NREQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_WR,
        WAIT_RD,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic                     write;
        logic [ARB_ADDRWIDTH-1:0] addr;
        logic [ARB_DATAWIDTH-1:0] wdata;
        logic [ARB_IDXW-1:0]      idx;
    } arb_cmd_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr_i, wrapping.
// Zero latency; no backpressure, ptr_i must be below NREQ.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDXW'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/i2c_access_arbiter.sv
// Round-robin arbiter sharing one i2c_wrapper port; grant+strobe 1 cycle after request, one command outstanding.
// Requesters hold req_valid until req_ready; responses are one-cycle pulses with no backpressure.
module i2c_access_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ       = ARB_NREQ,
    parameter int DATAWIDTH  = ARB_DATAWIDTH,
    parameter int ADDRWIDTH  = ARB_ADDRWIDTH,
    parameter int WR_HOLD    = ARB_WR_HOLD,
    parameter int RD_TIMEOUT = ARB_RD_TIMEOUT,
    parameter int LOAD_SEL   = ARB_LOAD_SEL
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_write,
    input  logic [NREQ*ADDRWIDTH-1:0]       req_addr,
    input  logic [NREQ*DATAWIDTH-1:0]       req_wdata,
    output logic [NREQ-1:0]                 req_ready,
    output logic [NREQ-1:0]                 rsp_valid,
    output logic [DATAWIDTH-1:0]            rsp_data,
    output logic                            rsp_error,
    output logic                            busy,
    output logic                            wr_en,
    output logic                            rd_en,
    output logic [ADDRWIDTH-1:0]            addr,
    output logic [DATAWIDTH-1:0]            D,
    output logic [$clog2(DATAWIDTH)-1:0]    S,
    output logic                            MSBIn,
    output logic                            LSBIn,
    input  logic [DATAWIDTH-1:0]            dataout,
    input  logic                            DataValid
);

    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = $clog2(max_int(WR_HOLD, RD_TIMEOUT) + 1);
    localparam int SW   = $clog2(DATAWIDTH);

    arb_state_t           state_q, state_d;
    arb_cmd_t             cmd_q, cmd_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]      req_ready_q, req_ready_d;
    logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 wr_en_q, wr_en_d;
    logic                 rd_en_q, rd_en_d;

    logic [NREQ-1:0]      pick_grant;
    logic [IDXW-1:0]      pick_idx;
    logic                 pick_any;
    logic                 sel_write;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic [CNTW-1:0]      cnt_inc;

    rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IDXW'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDRWIDTH +: ADDRWIDTH];
                sel_wdata = req_wdata[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    // Saturate rather than wrap so a stuck wait can never alias back to a match.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    cmd_d.write = sel_write;
                    cmd_d.addr  = sel_addr;
                    cmd_d.wdata = sel_wdata;
                    cmd_d.idx   = pick_idx;
                    req_ready_d = pick_grant;
                    wr_en_d     = sel_write;
                    rd_en_d     = !sel_write;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = cmd_q.write ? WAIT_WR : WAIT_RD;
            end
            WAIT_WR: begin
                cnt_d = cnt_inc;
                if (cnt_q == CNTW'(WR_HOLD - 1)) begin
                    rsp_valid_d = NREQ'(1) << cmd_q.idx;
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_inc;
                if (DataValid) begin
                    rsp_valid_d = NREQ'(1) << cmd_q.idx;
                    rsp_data_d  = dataout;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNTW'(RD_TIMEOUT - 1)) begin
                    rsp_valid_d = NREQ'(1) << cmd_q.idx;
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                rr_ptr_d = (cmd_q.idx == IDXW'(NREQ - 1)) ? '0 : cmd_q.idx + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;
    assign busy      = (state_q != IDLE);
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = cmd_q.addr;
    assign D         = cmd_q.wdata;
    assign S         = SW'(LOAD_SEL);
    assign MSBIn     = 1'b0;
    assign LSBIn     = 1'b0;

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// Directed bench for i2c_access_arbiter: vector table of single commands plus reset/fairness/abort sequences.
module tb_i2c_access_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_error;
    logic              busy;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     D;
    logic [2:0]        S;
    logic              MSBIn;
    logic              LSBIn;
    logic [DW-1:0]     dataout;
    logic              DataValid;

    always #5 clk = ~clk;

    i2c_access_arbiter #(
        .NREQ       (NREQ),
        .DATAWIDTH  (DW),
        .ADDRWIDTH  (AW),
        .WR_HOLD    (4),
        .RD_TIMEOUT (63),
        .LOAD_SEL   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .busy      (busy),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .D         (D),
        .S         (S),
        .MSBIn     (MSBIn),
        .LSBIn     (LSBIn),
        .dataout   (dataout),
        .DataValid (DataValid)
    );

    typedef struct {
        int         r;
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
        int         dv_k;      // DataValid in cycle 1+dv_k; 0 = never
        logic [7:0] dv_dat;
        int         exp_cyc;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [7];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [5:0] a, input logic [7:0] d);
        req_valid[r]           = 1'b1;
        req_write[r]           = wr;
        req_addr[r*AW +: AW]   = a;
        req_wdata[r*DW +: DW]  = d;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int              cyc;
        logic [NREQ-1:0] got;
        logic [7:0]      got_data;
        logic            got_err;
        string           tag;
        tag = $sformatf("vec%0d", n);
        cyc = 0;
        got = '0;
        got_data = '0;
        got_err = 1'b0;
        set_req(v.r, v.wr, v.a, v.d);
        while (got == '0 && cyc < 120) begin
            step();
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_ready"}, 32'(req_ready), 32'(1) << v.r);
                chk({tag, "_strobe"}, {30'd0, wr_en, rd_en}, {30'd0, v.wr, !v.wr});
                chk({tag, "_addr"}, 32'(addr), 32'(v.a));
                chk({tag, "_D"}, 32'(D), 32'(v.d));
                req_valid[v.r] = 1'b0;
            end
            if (cyc == 2)
                chk({tag, "_strobe_off"}, {30'd0, wr_en, rd_en}, 32'd0);
            if (rsp_valid != '0) begin
                got      = rsp_valid;
                got_data = rsp_data;
                got_err  = rsp_error;
            end
            DataValid = (v.dv_k > 0) && (cyc == 1 + v.dv_k);
            dataout   = DataValid ? v.dv_dat : 8'hEE;
        end
        DataValid = 1'b0;
        chk({tag, "_rsp_cycle"}, 32'(cyc), 32'(v.exp_cyc));
        chk({tag, "_rsp_valid"}, 32'(got), 32'(1) << v.r);
        chk({tag, "_rsp_data"}, 32'(got_data), 32'(v.exp_data));
        chk({tag, "_rsp_error"}, 32'(got_err), 32'(v.exp_err));
        step();
        chk({tag, "_rsp_pulse"}, {27'd0, rsp_valid, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               cyc;
        int               n;
        int               first_cyc;
        logic [NREQ-1:0]  last_grant;
        logic             stray;
        int               order [5];

        //           r  wr    addr   wdata  dv_k dv_dat exp_cyc exp_data exp_err
        vecs[0] = '{2, 1'b1, 6'h15, 8'hA5, 0,  8'h00, 6,  8'h00, 1'b0};
        vecs[1] = '{1, 1'b0, 6'h07, 8'h00, 3,  8'h3C, 5,  8'h3C, 1'b0};
        vecs[2] = '{3, 1'b0, 6'h2A, 8'h11, 1,  8'h81, 3,  8'h81, 1'b0};
        vecs[3] = '{0, 1'b1, 6'h3F, 8'h5A, 0,  8'h00, 6,  8'h00, 1'b0};
        vecs[4] = '{2, 1'b0, 6'h01, 8'h00, 0,  8'h00, 65, 8'h00, 1'b1};
        vecs[5] = '{1, 1'b0, 6'h20, 8'h00, 63, 8'hE7, 65, 8'hE7, 1'b0};
        vecs[6] = '{3, 1'b0, 6'h33, 8'h00, 62, 8'h5F, 64, 8'h5F, 1'b0};
        order = '{0, 1, 2, 3, 0};

        // Reset held with every requester asking and a stray DataValid.
        reset     = 1'b0;
        req_valid = 4'hF;
        req_write = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = AW'(6'h10 + i);
            req_wdata[i*DW +: DW] = DW'(8'hB0 + i);
        end
        DataValid = 1'b1;
        dataout   = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_outputs_c%0d", i),
                {req_ready, rsp_valid, rsp_data, rsp_error, busy, wr_en, rd_en, MSBIn, LSBIn},
                32'd0);
            chk($sformatf("reset_addr_D_c%0d", i), {18'd0, addr, D}, 32'd0);
            chk($sformatf("reset_S_c%0d", i), 32'(S), 32'd3);
        end
        DataValid = 1'b0;
        reset     = 1'b1;

        // Fairness: all four continuously valid writes.
        n          = 0;
        cyc        = 0;
        first_cyc  = -1;
        last_grant = '0;
        while (n < 5 && cyc < 100) begin
            step();
            cyc++;
            if (rsp_valid != '0)
                chk($sformatf("fair_rsp%0d", n), 32'(rsp_valid), 32'(last_grant));
            if (req_ready != '0) begin
                if (n == 0) first_cyc = cyc;
                chk($sformatf("fair_grant%0d", n), 32'(req_ready), 32'(1) << order[n]);
                chk($sformatf("fair_addr%0d", n), 32'(addr), 32'h10 + 32'(order[n]));
                last_grant = req_ready;
                n++;
            end
        end
        req_valid = '0;
        chk("fair_grant_count", 32'(n), 32'd5);
        chk("fair_first_cycle", 32'(first_cyc), 32'd1);
        cyc = 0;
        while (busy && cyc < 100) begin
            step();
            cyc++;
        end
        chk("fair_drain", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], i);

        // Reset while waiting for read data, then a stray DataValid.
        set_req(0, 1'b0, 6'h07, 8'h00);
        step();
        chk("abort_ready", 32'(req_ready), 32'd1);
        req_valid = '0;
        step();
        step();
        chk("abort_in_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("abort_idle", {30'd0, busy, |rsp_valid}, 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            DataValid = (i == 2);
            dataout   = 8'h99;
            step();
            if (rsp_valid != '0 || busy || rsp_data != '0) stray = 1'b1;
        end
        DataValid = 1'b0;
        chk("abort_stray_dv", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_access_arbiter.md
# i2c_access_arbiter

Round-robin arbiter that shares the single `i2c_wrapper` write/read path among `NREQ` requesters. It latches one command at a time, drives the wrapper's `wr_en`/`rd_en`/`addr`/`D`/`S` for exactly one cycle, and waits for completion: `DataValid` for reads, a fixed hold count for writes. It then returns a per-requester response, with a timeout for reads that never complete.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DATAWIDTH`, 8: data width; matches wrapper.
- `ADDRWIDTH`, 6: address width; matches wrapper.
- `WR_HOLD`, 4: cycles to wait after a write issue before the write is considered done (1..15).
- `RD_TIMEOUT`, 63: max cycles to wait for `DataValid` after a read issue.
- `LOAD_SEL`, 3: value driven on `S` (shift-register parallel-load select).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `req_valid`  in  NREQ  request pending per requester; held until `req_ready`.
- `req_write`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*ADDRWIDTH  packed addresses; requester i occupies slice [i*ADDRWIDTH +: ADDRWIDTH].
- `req_wdata`  in  NREQ*DATAWIDTH  packed write data, same slicing.
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  NREQ  one-hot, one-cycle completion pulse.
- `rsp_data`  out  DATAWIDTH  read data; valid with `rsp_valid`.
- `rsp_error`  out  1  read timed out; valid with `rsp_valid`.
- `busy`  out  1  high in any state except IDLE.
- `wr_en`, `rd_en`  out  1  to wrapper.
- `addr`  out  ADDRWIDTH  to wrapper.
- `D`  out  DATAWIDTH  to wrapper.
- `S`  out  clog2(DATAWIDTH)  to wrapper; constant `LOAD_SEL`.
- `MSBIn`, `LSBIn`  out  1  tied 0.
- `dataout`  in  DATAWIDTH  from wrapper.
- `DataValid`  in  1  from wrapper.

## Operation
- FSM states are IDLE, ISSUE, WAIT_WR, WAIT_RD and RESP.
- **IDLE:** if any `req_valid`, pick the winner by round-robin, starting the search at pointer `rr_ptr`.
  - Latch the winner's index, write bit, addr and wdata.
  - Register `req_ready[winner]` = 1 for the next cycle.
  - Go to ISSUE.
- **ISSUE:** drive `wr_en` = write or `rd_en` = !write for this cycle only, with `addr`/`D` from the latch.
  - Clear the cycle counter.
  - Go to WAIT_WR if write, otherwise WAIT_RD.
- **WAIT_WR:** count cycles; when count = `WR_HOLD`-1, go to RESP with `rsp_error` = 0 and `rsp_data` = 0.
- **WAIT_RD:**
  - On `DataValid`, capture `dataout` into `rsp_data`, set `rsp_error` = 0, go to RESP.
  - Otherwise, when count = `RD_TIMEOUT`-1, set `rsp_data` = 0, `rsp_error` = 1, go to RESP.
  - `DataValid` wins if it arrives on the timeout cycle.
- **RESP:** assert `rsp_valid[winner]` for one cycle, set `rr_ptr` = (winner+1) mod `NREQ`, go to IDLE.
- `addr`/`D` hold their latched values outside ISSUE. `wr_en`/`rd_en` are 0 outside ISSUE.
- `DataValid` outside WAIT_RD is ignored.
- A requester may drop `req_valid` only after `req_ready`. A command already latched is completed regardless.
- Counter width is clog2(max(`WR_HOLD`,`RD_TIMEOUT`)+1) and the counter saturates, never wraps.
- **Reset** (low at a clock edge, any state):
  - state IDLE, `rr_ptr` 0.
  - All outputs 0 except `S` = `LOAD_SEL`.
  - An in-flight command is dropped with no response.

## Timing
- Request seen in IDLE at cycle 0 → `req_ready` high in cycle 1 and `wr_en`/`rd_en` high in cycle 1, both registered.
- Write: `rsp_valid` in cycle 2+`WR_HOLD`.
- Read: with `DataValid` in cycle 1+k (k ≥ 1), `rsp_valid` is in cycle 2+k.
- Read timeout: `rsp_valid` in cycle 2+`RD_TIMEOUT`.
- Back-to-back: the earliest next grant is evaluated in the cycle after RESP. This gives one idle cycle minimum between commands.
- Only one command is outstanding at any time.

## Structure
- Package `i2c_arb_pkg`:
  - State enum `arb_state_t` {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP}.
  - A command struct (write, addr, wdata, index).
  - Default parameter constants.
- Sub-module `rr_picker`: combinational, takes `req` vector and `ptr` and returns one-hot grant plus index. Instantiated once.
- The top level instantiates the arbiter in front of `i2c_wrapper`. The arbiter's `clk`/`reset` connect directly to the wrapper's.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles with all `req_valid` = 1.
  - Required: all outputs 0 and `S` = 3.
  - After release: requester 0 granted first.
- **Single write:** req 2 writes addr 0x15, data 0xA5.
  - `req_ready` = 4'b0100 and `wr_en` = 1 with addr 0x15, D 0xA5 in cycle 1.
  - `rsp_valid` = 4'b0100 in cycle 6, `rsp_error` = 0.
- **Single read:** req 1 reads addr 0x07, with the model returning `DataValid` and `dataout` = 0x3C three cycles after `rd_en`.
  - `rsp_valid[1]` one cycle later, `rsp_data` = 0x3C.
- **Fairness:** all four requesters continuously valid, writes.
  - Grant order is 0,1,2,3,0; no requester is granted twice before the others.
- **Timeout:** read with no `DataValid`.
  - `rsp_valid` 2+63 cycles after the request, `rsp_error` = 1, `rsp_data` = 0.
  - A `DataValid` pulse injected exactly on the last wait cycle instead yields `rsp_error` = 0.
- **Reset mid-read:** pull `reset` low in WAIT_RD.
  - No `rsp_valid` pulse; `busy` = 0 the next cycle.
  - A stray later `DataValid` has no effect.
